// File: rtl/shift_counter_pkg.sv
// Shared constants and the initial-state helper for the ring/Johnson shift counter.
package shift_counter_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // Ring starts with only bit 0 set; Johnson starts empty.
  function automatic logic [MAX_W-1:0] init_state(input logic mode, input int unsigned width);
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    return (mode == MODE_JOHNSON) ? '0 : (MAX_W'(1) & mask);
  endfunction

endpackage

// File: rtl/shift_counter_legal.sv
// Combinational legality check of a counter state for the given mode.
module shift_counter_legal
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_mode,
  output logic             o_legal
);

  logic [WIDTH-1:0] w_inv;
  logic             w_ring_ok;
  logic             w_fill_lo;
  logic             w_fill_hi;

  // A low-filled thermometer code is 2^k-1, so adding one clears every set bit.
  assign w_inv     = ~i_val;
  assign w_ring_ok = ($countones(i_val) == 1);
  assign w_fill_lo = ((i_val & (i_val + WIDTH'(1))) == '0);
  assign w_fill_hi = ((w_inv & (w_inv + WIDTH'(1))) == '0);

  assign o_legal = (i_mode == MODE_JOHNSON) ? (w_fill_lo | w_fill_hi) : w_ring_ok;

endmodule

// File: rtl/shift_counter.sv
// WIDTH-bit ring / Johnson shift counter with direction, enable, checked load,
// wrap pulse and self-correction of illegal states.
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             fault
);

  logic [WIDTH-1:0] r_q;
  logic             r_mode_q;
  logic             r_wrap;
  logic             r_fault;

  logic [WIDTH-1:0] w_init_mode;
  logic [WIDTH-1:0] w_init_held;
  logic [WIDTH-1:0] w_step;
  logic             w_load_legal;
  logic             w_q_legal;

  assign w_init_mode = WIDTH'(init_state(mode, WIDTH));
  assign w_init_held = WIDTH'(init_state(r_mode_q, WIDTH));

  shift_counter_legal #(.WIDTH(WIDTH)) u_legal_load (
    .i_val   (load_val),
    .i_mode  (mode),
    .o_legal (w_load_legal)
  );

  shift_counter_legal #(.WIDTH(WIDTH)) u_legal_q (
    .i_val   (r_q),
    .i_mode  (r_mode_q),
    .o_legal (w_q_legal)
  );

  always_comb begin
    w_step = r_q;
    case ({r_mode_q, dir})
      {MODE_RING,    DIR_UP}:   w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      {MODE_RING,    DIR_DOWN}: w_step = {r_q[0], r_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_UP}:   w_step = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_DOWN}: w_step = {~r_q[0], r_q[WIDTH-1:1]};
      default:                  w_step = r_q;
    endcase
  end

  // Priority: clear, load, mode change, upset correction, step, hold.
  always_ff @(posedge clk) begin
    r_wrap  <= 1'b0;
    r_fault <= 1'b0;
    if (clear) begin
      r_q      <= w_init_mode;
      r_mode_q <= mode;
    end else if (load) begin
      r_mode_q <= mode;
      if (w_load_legal) begin
        r_q <= load_val;
      end else begin
        r_q     <= w_init_mode;
        r_fault <= 1'b1;
      end
    end else if (mode != r_mode_q) begin
      r_q      <= w_init_mode;
      r_mode_q <= mode;
    end else if (!w_q_legal) begin
      r_q     <= w_init_held;
      r_fault <= 1'b1;
    end else if (en) begin
      r_q    <= w_step;
      r_wrap <= (w_step == w_init_held);
    end
  end

  assign q     = r_q;
  assign wrap  = r_wrap;
  assign fault = r_fault;

endmodule

// File: tb/tb_shift_counter.sv
// Scoreboard bench for shift_counter at WIDTH=4 and WIDTH=8.
module tb_shift_counter;

  typedef struct {
    int          sel;
    logic [31:0] q;
    bit          wrap;
    bit          fault;
  } exp_t;

  logic       clk;
  logic       t_clear [2];
  logic       t_en    [2];
  logic       t_dir   [2];
  logic       t_mode  [2];
  logic       t_load  [2];
  logic [3:0] lv4;
  logic [7:0] lv8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       wrap4, wrap8, fault4, fault8;

  int          n_chk;
  int          n_fail;
  exp_t        sbq[$];
  logic [31:0] m_q  [2];
  bit          m_md [2];
  int          m_w  [2];

  shift_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .clear(t_clear[0]), .en(t_en[0]), .dir(t_dir[0]), .mode(t_mode[0]),
    .load(t_load[0]), .load_val(lv4), .q(q4), .wrap(wrap4), .fault(fault4)
  );

  shift_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clear(t_clear[1]), .en(t_en[1]), .dir(t_dir[1]), .mode(t_mode[1]),
    .load(t_load[1]), .load_val(lv8), .q(q8), .wrap(wrap8), .fault(fault8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] m_init(input bit md);
    return md ? 32'd0 : 32'd1;
  endfunction

  function automatic bit m_legal(input logic [31:0] v, input bit md, input int w);
    int          n;
    bit          ok;
    logic [31:0] lo;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < w; i++) n += int'(v[i]);
    if (!md) return (n == 1);
    for (int k = 0; k <= w; k++) begin
      lo = m_mask(k);
      if (v == lo || v == (m_mask(w) & ~lo)) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] v, input bit d, input bit md, input int w);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < w; i++) begin
      if (!d) n[i] = (i == 0) ? (md ? ~v[w-1] : v[w-1]) : v[i-1];
      else    n[i] = (i == w-1) ? (md ? ~v[0] : v[0]) : v[i+1];
    end
    return n;
  endfunction

  // One clock: drive the selected instance, predict, then compare its outputs.
  task automatic cyc(input int s, input bit c, input bit e, input bit d, input bit md,
                     input bit ld, input logic [31:0] lv);
    exp_t        x;
    logic [31:0] nq;
    bit          wr, ft;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      t_clear[k] = 1'b0; t_en[k] = 1'b0; t_dir[k] = 1'b0; t_load[k] = 1'b0; t_mode[k] = m_md[k];
    end
    t_clear[s] = c; t_en[s] = e; t_dir[s] = d; t_mode[s] = md; t_load[s] = ld;
    lv4 = lv[3:0];
    lv8 = lv[7:0];
    nq = m_q[s]; wr = 1'b0; ft = 1'b0;
    if (c) begin
      nq = m_init(md); m_md[s] = md;
    end else if (ld) begin
      m_md[s] = md;
      if (m_legal(lv & m_mask(m_w[s]), md, m_w[s])) nq = lv & m_mask(m_w[s]);
      else begin nq = m_init(md); ft = 1'b1; end
    end else if (md != m_md[s]) begin
      nq = m_init(md); m_md[s] = md;
    end else if (!m_legal(m_q[s], m_md[s], m_w[s])) begin
      nq = m_init(m_md[s]); ft = 1'b1;
    end else if (e) begin
      nq = m_step(m_q[s], d, m_md[s], m_w[s]);
      wr = (nq == m_init(m_md[s]));
    end
    m_q[s] = nq;
    x.sel = s; x.q = nq; x.wrap = wr; x.fault = ft;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    if (x.sel == 0) begin
      chk("q4", {28'd0, q4}, x.q);
      chk("wrap4", {31'd0, wrap4}, {31'd0, x.wrap});
      chk("fault4", {31'd0, fault4}, {31'd0, x.fault});
    end else begin
      chk("q8", {24'd0, q8}, x.q);
      chk("wrap8", {31'd0, wrap8}, {31'd0, x.wrap});
      chk("fault8", {31'd0, fault8}, {31'd0, x.fault});
    end
  endtask

  logic [3:0] ring_tbl [8];
  logic [3:0] john_tbl [8];
  int         last_wrap;
  int         n_wrap;

  initial begin
    n_chk = 0; n_fail = 0;
    m_w[0] = 4; m_w[1] = 8;
    m_q[0] = '0; m_q[1] = '0; m_md[0] = 1'b0; m_md[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_clear[k] = 1'b1; t_en[k] = 1'b0; t_dir[k] = 1'b0; t_mode[k] = 1'b0; t_load[k] = 1'b0;
    end
    lv4 = '0; lv8 = '0;
    ring_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    john_tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    // Reset state and ring counting upward
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("reset_q4", {28'd0, q4}, 32'h1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("ring_tbl", {28'd0, q4}, {28'd0, ring_tbl[i]});
      chk("ring_wrap", {31'd0, wrap4}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end

    // Johnson sequence, then reverse direction at 0111
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("mode_sw_q", {28'd0, q4}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 1, 0, 0);
      chk("john_tbl", {28'd0, q4}, {28'd0, john_tbl[i]});
    end
    chk("john_wrap", {31'd0, wrap4}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("john_dn1", {28'd0, q4}, 32'h3);
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("john_dn2", {28'd0, q4}, 32'h1);

    // Load legality
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h6);
    chk("ld_bad_ring_q", {28'd0, q4}, 32'h1);
    chk("ld_bad_ring_f", {31'd0, fault4}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1, 32'h4);
    chk("ld_ok_ring", {28'd0, q4}, 32'h4);
    cyc(0, 0, 0, 0, 1, 1, 32'hC);
    chk("ld_ok_john", {28'd0, q4}, 32'hC);
    cyc(0, 0, 0, 0, 1, 1, 32'h5);
    chk("ld_bad_john_f", {31'd0, fault4}, 32'd1);

    // Mode change mid-run, then Johnson stepping
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    chk("mode_chg_f", {31'd0, fault4}, 32'd0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    chk("mode_chg_seq", {28'd0, q4}, 32'h3);

    // Upset injection in ring mode with en low
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    #2;
    force u_dut4.r_q = 4'b0011;
    #1;
    release u_dut4.r_q;
    m_q[0] = 32'h3;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("upset_q", {28'd0, q4}, 32'h1);
    chk("upset_f", {31'd0, fault4}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("upset_f_once", {31'd0, fault4}, 32'd0);

    // Load beats en
    cyc(0, 0, 1, 0, 0, 1, 32'h8);
    chk("ld_vs_en", {28'd0, q4}, 32'h8);

    // WIDTH=8: clear beats load, then Johnson wrap period
    cyc(1, 1, 0, 0, 1, 1, 32'h0F);
    chk("clr_ld_q8", {24'd0, q8}, 32'h0);
    chk("clr_ld_f8", {31'd0, fault8}, 32'd0);
    last_wrap = -1;
    n_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 1, 0, 1, 0, 0);
      if (wrap8) begin
        if (last_wrap >= 0) chk("wrap8_period", i - last_wrap, 32'd16);
        last_wrap = i;
        n_wrap++;
      end
    end
    chk("wrap8_count", n_wrap, 32'd2);

    // Random mix on WIDTH=4
    for (int i = 0; i < 60; i++) begin
      cyc(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0) ? ~m_md[0] : m_md[0],
          ($urandom_range(0, 5) == 0), $urandom_range(0, 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
